// File: rtl/hazard_ctrl.sv
// Hazard and forwarding controller for the pipelined RV32 core: stall/flush
// enables for every pipeline register, execute forwarding selects, stall counter.
module hazard_ctrl #(
    parameter int REG_ADDR_WIDTH = 5,
    parameter int MC_LATENCY     = 4,
    parameter int CNT_WIDTH      = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [REG_ADDR_WIDTH-1:0] rs1_d,
    input  logic [REG_ADDR_WIDTH-1:0] rs2_d,
    input  logic [REG_ADDR_WIDTH-1:0] rs1_e,
    input  logic [REG_ADDR_WIDTH-1:0] rs2_e,
    input  logic [REG_ADDR_WIDTH-1:0] rd_e,
    input  logic [1:0]                res_src_e,
    input  logic                      reg_write_e,
    input  logic [REG_ADDR_WIDTH-1:0] rd_m,
    input  logic [REG_ADDR_WIDTH-1:0] rd_w,
    input  logic                      reg_write_m,
    input  logic                      reg_write_w,
    input  logic                      pc_src_e,
    input  logic                      mc_start_e,
    input  logic                      mem_req_m,
    input  logic                      mem_ready_m,
    output logic [1:0]                forward_a_e,
    output logic [1:0]                forward_b_e,
    output logic                      stall_f,
    output logic                      stall_d,
    output logic                      stall_e,
    output logic                      stall_m,
    output logic                      flush_d,
    output logic                      flush_e,
    output logic                      flush_m,
    output logic                      flush_w,
    output logic                      mc_busy,
    output logic [CNT_WIDTH-1:0]      stall_cycles
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } mc_state_t;

    localparam logic [4:0] LAT   = 5'(MC_LATENCY);
    localparam logic       MC_EN = (MC_LATENCY > 0);

    mc_state_t                r_state;
    mc_state_t                w_state_next;
    logic [3:0]               r_mc_cnt;
    logic [3:0]               w_mc_cnt_next;
    logic                     r_mc_busy;
    logic [CNT_WIDTH-1:0]     r_stall_cnt;

    logic                     w_mem_wait;
    logic                     w_mc_stall;
    logic                     w_load_use;
    logic                     w_branch;
    logic [REG_ADDR_WIDTH-1:0] w_rs_e [2];
    logic [1:0]               w_fwd  [2];

    assign w_rs_e[0] = rs1_e;
    assign w_rs_e[1] = rs2_e;

    // Memory stage result is younger than writeback, so it wins.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_fwd
            assign w_fwd[gi] = (reg_write_m && (rd_m == w_rs_e[gi]) && (rd_m != '0)) ? 2'b10 :
                               (reg_write_w && (rd_w == w_rs_e[gi]) && (rd_w != '0)) ? 2'b01 :
                                                                                      2'b00;
        end
    endgenerate

    assign forward_a_e = w_fwd[0];
    assign forward_b_e = w_fwd[1];

    assign w_mem_wait = mem_req_m & ~mem_ready_m;
    assign w_load_use = (res_src_e == 2'b01) & reg_write_e & (rd_e != '0) &
                        ((rd_e == rs1_d) | (rd_e == rs2_d));
    assign w_mc_stall = ~w_mem_wait &
                        (((r_state == IDLE) & mc_start_e & MC_EN) | (r_state == BUSY));
    assign w_branch   = pc_src_e & ~w_mem_wait & ~w_mc_stall;

    // r_mc_cnt holds the number of stall cycles already completed for the op.
    // The whole sequencer is frozen while data memory is waiting.
    always_comb begin
        w_state_next  = r_state;
        w_mc_cnt_next = r_mc_cnt;
        if (!w_mem_wait) begin
            case (r_state)
                IDLE: begin
                    if (mc_start_e && MC_EN) begin
                        if (LAT == 5'd1) begin
                            w_state_next = DONE;
                        end else begin
                            w_state_next  = BUSY;
                            w_mc_cnt_next = 4'd1;
                        end
                    end
                end
                BUSY: begin
                    if (({1'b0, r_mc_cnt} + 5'd1) == LAT) begin
                        w_state_next  = DONE;
                        w_mc_cnt_next = 4'd0;
                    end else begin
                        w_mc_cnt_next = r_mc_cnt + 4'd1;
                    end
                end
                DONE: begin
                    w_state_next  = IDLE;
                    w_mc_cnt_next = 4'd0;
                end
                default: begin
                    w_state_next  = IDLE;
                    w_mc_cnt_next = 4'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= IDLE;
            r_mc_cnt  <= 4'd0;
            r_mc_busy <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_mc_cnt  <= w_mc_cnt_next;
            r_mc_busy <= (w_state_next != IDLE);
        end
    end

    always_comb begin
        stall_f = 1'b0;
        stall_d = 1'b0;
        stall_e = 1'b0;
        stall_m = 1'b0;
        flush_d = 1'b0;
        flush_e = 1'b0;
        flush_m = 1'b0;
        flush_w = 1'b0;
        if (!rst) begin
            flush_d = 1'b1;
            flush_e = 1'b1;
            flush_m = 1'b1;
            flush_w = 1'b1;
        end else if (w_mem_wait) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            stall_e = 1'b1;
            stall_m = 1'b1;
            flush_w = 1'b1;
        end else if (w_mc_stall) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            stall_e = 1'b1;
            flush_m = 1'b1;
        end else if (w_branch) begin
            flush_d = 1'b1;
            flush_e = 1'b1;
        end else if (w_load_use) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            flush_e = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_stall_cnt <= '0;
        end else if (stall_f && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

    assign mc_busy      = r_mc_busy;
    assign stall_cycles = r_stall_cnt;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed plus randomized bench for hazard_ctrl, checked against a
// count-down behavioural model of the stall/flush/forward rules.
module tb_hazard_ctrl;

    localparam int AW  = 5;
    localparam int LAT = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic [AW-1:0] rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
    logic [1:0]    res_src_e;
    logic          reg_write_e, reg_write_m, reg_write_w;
    logic          pc_src_e, mc_start_e, mem_req_m, mem_ready_m;

    logic [1:0]  fwd_a, fwd_b, s_fwd_a, s_fwd_b;
    logic        st_f, st_d, st_e, st_m, fl_d, fl_e, fl_m, fl_w, busy;
    logic        s_st_f, s_st_d, s_st_e, s_st_m, s_fl_d, s_fl_e, s_fl_m, s_fl_w, s_busy;
    logic [15:0] cnt;
    logic [3:0]  s_cnt;

    hazard_ctrl #(.REG_ADDR_WIDTH(AW), .MC_LATENCY(LAT), .CNT_WIDTH(16)) dut (
        .clk(clk), .rst(rst),
        .rs1_d(rs1_d), .rs2_d(rs2_d), .rs1_e(rs1_e), .rs2_e(rs2_e), .rd_e(rd_e),
        .res_src_e(res_src_e), .reg_write_e(reg_write_e),
        .rd_m(rd_m), .rd_w(rd_w), .reg_write_m(reg_write_m), .reg_write_w(reg_write_w),
        .pc_src_e(pc_src_e), .mc_start_e(mc_start_e),
        .mem_req_m(mem_req_m), .mem_ready_m(mem_ready_m),
        .forward_a_e(fwd_a), .forward_b_e(fwd_b),
        .stall_f(st_f), .stall_d(st_d), .stall_e(st_e), .stall_m(st_m),
        .flush_d(fl_d), .flush_e(fl_e), .flush_m(fl_m), .flush_w(fl_w),
        .mc_busy(busy), .stall_cycles(cnt)
    );

    hazard_ctrl #(.REG_ADDR_WIDTH(AW), .MC_LATENCY(LAT), .CNT_WIDTH(4)) dut_sat (
        .clk(clk), .rst(rst),
        .rs1_d(rs1_d), .rs2_d(rs2_d), .rs1_e(rs1_e), .rs2_e(rs2_e), .rd_e(rd_e),
        .res_src_e(res_src_e), .reg_write_e(reg_write_e),
        .rd_m(rd_m), .rd_w(rd_w), .reg_write_m(reg_write_m), .reg_write_w(reg_write_w),
        .pc_src_e(pc_src_e), .mc_start_e(mc_start_e),
        .mem_req_m(mem_req_m), .mem_ready_m(mem_ready_m),
        .forward_a_e(s_fwd_a), .forward_b_e(s_fwd_b),
        .stall_f(s_st_f), .stall_d(s_st_d), .stall_e(s_st_e), .stall_m(s_st_m),
        .flush_d(s_fl_d), .flush_e(s_fl_e), .flush_m(s_fl_m), .flush_w(s_fl_w),
        .mc_busy(s_busy), .stall_cycles(s_cnt)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Model: stall cycles still owed by the current op, and whether it sits in its final no-stall cycle.
    int m_left     = 0;
    bit m_done     = 1'b0;
    int m_cnt      = 0;
    int m_cnt_sat  = 0;
    int base;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] ref_fwd(input logic [AW-1:0] rs);
        if (reg_write_m && rd_m == rs && rd_m != 0) return 2'b10;
        if (reg_write_w && rd_w == rs && rd_w != 0) return 2'b01;
        return 2'b00;
    endfunction

    task automatic model_reset();
        m_left    = 0;
        m_done    = 1'b0;
        m_cnt     = 0;
        m_cnt_sat = 0;
    endtask

    task automatic clr();
        rs1_d = '0; rs2_d = '0; rs1_e = '0; rs2_e = '0; rd_e = '0; rd_m = '0; rd_w = '0;
        res_src_e = 2'b00; reg_write_e = 0; reg_write_m = 0; reg_write_w = 0;
        pc_src_e = 0; mc_start_e = 0; mem_req_m = 0; mem_ready_m = 1;
    endtask

    // Called right after inputs change at a negedge; checks, clocks the model, returns at the next negedge.
    task automatic step(input string tag);
        bit mw, idle, mcs, lu, br;
        logic [3:0] e_stall, e_flush;
        #1;
        mw   = mem_req_m && !mem_ready_m;
        idle = (m_left == 0) && !m_done;
        mcs  = !mw && (m_left > 0 || (idle && mc_start_e && LAT > 0));
        lu   = res_src_e == 2'b01 && reg_write_e && rd_e != 0 && (rd_e == rs1_d || rd_e == rs2_d);
        br   = pc_src_e && !mw && !mcs;
        if (!rst)      begin e_stall = 4'b0000; e_flush = 4'b1111; end
        else if (mw)   begin e_stall = 4'b1111; e_flush = 4'b0001; end
        else if (mcs)  begin e_stall = 4'b1110; e_flush = 4'b0010; end
        else if (br)   begin e_stall = 4'b0000; e_flush = 4'b1100; end
        else if (lu)   begin e_stall = 4'b1100; e_flush = 4'b0100; end
        else           begin e_stall = 4'b0000; e_flush = 4'b0000; end
        chk({tag, ".fwd_a"}, 32'(fwd_a), 32'(ref_fwd(rs1_e)));
        chk({tag, ".fwd_b"}, 32'(fwd_b), 32'(ref_fwd(rs2_e)));
        chk({tag, ".stall"}, 32'({st_f, st_d, st_e, st_m}), 32'(e_stall));
        chk({tag, ".flush"}, 32'({fl_d, fl_e, fl_m, fl_w}), 32'(e_flush));
        chk({tag, ".busy"}, 32'(busy), 32'(!idle));
        chk({tag, ".cnt"}, 32'(cnt), 32'(m_cnt));
        chk({tag, ".cnt_sat"}, 32'(s_cnt), 32'(m_cnt_sat));
        chk({tag, ".sat_stall"}, 32'({s_st_f, s_fl_d}), 32'({e_stall[3], e_flush[3]}));
        $display("%s t=%0t stall=%b flush=%b fwd=%0d/%0d busy=%b cnt=%0d sat=%0d",
                 tag, $time, {st_f, st_d, st_e, st_m}, {fl_d, fl_e, fl_m, fl_w},
                 fwd_a, fwd_b, busy, cnt, s_cnt);
        @(posedge clk);
        if (rst) begin
            if (e_stall[3]) begin
                if (m_cnt < 65535) m_cnt++;
                if (m_cnt_sat < 15) m_cnt_sat++;
            end
            if (!mw) begin
                if (idle && mc_start_e && LAT > 0) begin
                    m_left = LAT - 1;
                    m_done = (m_left == 0);
                end else if (m_left > 0) begin
                    m_left--;
                    m_done = (m_left == 0);
                end else if (m_done) begin
                    m_done = 1'b0;
                end
            end
        end else begin
            model_reset();
        end
        @(negedge clk);
    endtask

    task automatic set_load_use(input logic [AW-1:0] rd);
        res_src_e = 2'b01; reg_write_e = 1; rd_e = rd; rs2_d = 5'd3;
    endtask

    initial begin
        rst = 1'b0;
        clr();
        model_reset();
        @(negedge clk);
        step("reset0");
        step("reset1");
        rst = 1'b1;
        step("idle");

        // Forwarding priority
        rd_m = 5; rd_w = 5; rs1_e = 5; reg_write_m = 1; reg_write_w = 1;
        #1 chk("fwd_from_m", 32'(fwd_a), 32'h2);
        step("fwd_m");
        reg_write_m = 0;
        #1 chk("fwd_from_w", 32'(fwd_a), 32'h1);
        step("fwd_w");
        reg_write_m = 1; rs1_e = 0; rd_m = 0; rd_w = 0;
        #1 chk("fwd_x0", 32'(fwd_a), 32'h0);
        step("fwd_x0");

        // Load-use, then the same with rd_e = x0
        clr();
        base = int'(cnt);
        set_load_use(5'd3);
        step("lu");
        clr();
        step("lu_after");
        chk("lu_delta", 32'(int'(cnt) - base), 32'd1);
        set_load_use(5'd0);
        step("lu_x0");
        clr();

        // Multi-cycle op: 4 stall cycles then a DONE cycle
        base = int'(cnt);
        mc_start_e = 1;
        for (int i = 0; i < 5; i++) step("mc");
        mc_start_e = 0;
        step("mc_idle");
        chk("mc_delta", 32'(int'(cnt) - base), 32'd4);

        // Memory wait while BUSY at count 2
        base = int'(cnt);
        mc_start_e = 1;
        step("mcw0");
        step("mcw1");
        mem_req_m = 1; mem_ready_m = 0;
        for (int i = 0; i < 3; i++) step("mcw_wait");
        mem_ready_m = 1;
        for (int i = 0; i < 3; i++) step("mcw_tail");
        mc_start_e = 0; mem_req_m = 0;
        step("mcw_idle");
        chk("mcw_delta", 32'(int'(cnt) - base), 32'd7);

        // Branch held by a memory wait, then branch against load-use
        clr();
        pc_src_e = 1; mem_req_m = 1; mem_ready_m = 0;
        step("br_wait0");
        step("br_wait1");
        mem_ready_m = 1;
        #1 chk("br_release", 32'({fl_d, fl_e}), 32'h3);
        step("br_go");
        set_load_use(5'd3);
        #1 chk("br_lu_nostall", 32'(st_f), 32'h0);
        step("br_lu");
        clr();

        // Asynchronous reset in the middle of BUSY, restart on held mc_start_e
        mc_start_e = 1;
        step("rb0");
        step("rb1");
        #2 rst = 1'b0;
        #1;
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_flush", 32'({fl_d, fl_e, fl_m, fl_w}), 32'hf);
        chk("rst_stall", 32'({st_f, st_d, st_e, st_m}), 32'h0);
        model_reset();
        @(negedge clk);
        step("rb_hold");
        rst = 1'b1;
        for (int i = 0; i < 5; i++) step("rb_restart");
        mc_start_e = 0;
        step("rb_idle");

        // Saturation of the narrow counter
        set_load_use(5'd3);
        for (int i = 0; i < 20; i++) step("sat");
        clr();
        chk("sat_value", 32'(s_cnt), 32'd15);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            rs1_d = 5'($urandom_range(0, 3)); rs2_d = 5'($urandom_range(0, 3));
            rs1_e = 5'($urandom_range(0, 3)); rs2_e = 5'($urandom_range(0, 3));
            rd_e  = 5'($urandom_range(0, 3)); rd_m  = 5'($urandom_range(0, 3));
            rd_w  = 5'($urandom_range(0, 3));
            res_src_e   = 2'($urandom_range(0, 3));
            reg_write_e = 1'($urandom_range(0, 1));
            reg_write_m = 1'($urandom_range(0, 1));
            reg_write_w = 1'($urandom_range(0, 1));
            pc_src_e    = ($urandom_range(0, 3) == 0);
            mc_start_e  = ($urandom_range(0, 3) == 0);
            mem_req_m   = ($urandom_range(0, 2) == 0);
            mem_ready_m = 1'($urandom_range(0, 1));
            step("rnd");
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Parametrised hazard and forwarding controller for the pipelined RV32 core, replacing the flush-only hazard unit. It drives the stall and flush enables of every pipeline register and the forwarding selects into execute. It sequences three kinds of stall: load-use, multi-cycle execute ops, and wait-state data memory. A saturating stall-cycle counter is provided for performance measurement.

## Interface
- REG_ADDR_WIDTH, 5, register index width
- MC_LATENCY, 4, stall cycles a multi-cycle execute op holds E (0 = feature off, max 15)
- CNT_WIDTH, 16, stall-cycle counter width
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset
- rs1_d, rs2_d  in  REG_ADDR_WIDTH  source registers in decode
- rs1_e, rs2_e, rd_e  in  REG_ADDR_WIDTH  sources/dest in execute
- res_src_e  in  2  result select in E; 2'b01 = load
- reg_write_e  in  1  E writes a register
- rd_m, rd_w  in  REG_ADDR_WIDTH  dest in memory / writeback
- reg_write_m, reg_write_w  in  1  M / W write a register
- pc_src_e  in  1  taken branch/jump resolved in E
- mc_start_e  in  1  multi-cycle op present in E
- mem_req_m, mem_ready_m  in  1  data-memory access in M / completion
- forward_a_e, forward_b_e  out  2  00 regfile, 01 from W, 10 from M
- stall_f, stall_d, stall_e, stall_m  out  1  hold PC / pipeline register
- flush_d, flush_e, flush_m, flush_w  out  1  insert bubble into register
- mc_busy  out  1  multi-cycle sequencer not IDLE
- stall_cycles  out  CNT_WIDTH  saturating count of cycles with stall_f=1

## Operation
- Forwarding, per operand: 10 if reg_write_m and rd_m==rs?_e and rd_m!=0; else 01 if reg_write_w and rd_w==rs?_e and rd_w!=0; else 00. M has priority over W. This path is purely combinational.
- Load-use: load_use = (res_src_e==2'b01) & reg_write_e & rd_e!=0 & (rd_e==rs1_d | rd_e==rs2_d).
  - Effect: stall_f, stall_d, flush_e.
- Memory wait: mem_wait = mem_req_m & ~mem_ready_m.
  - Effect: stall_f/d/e/m, flush_w.
  - Overrides every other condition. No flush_d/e/m is asserted while mem_wait=1.
- Multi-cycle FSM with states IDLE, BUSY, DONE:
  - IDLE->BUSY when mc_start_e=1, MC_LATENCY>0 and mem_wait=0. The entry cycle is itself a stall cycle.
  - BUSY holds until exactly MC_LATENCY stall cycles have elapsed, then goes to DONE.
  - DONE lasts one cycle, with no stall. The op leaves E on that edge. mc_start_e is ignored in DONE. Next state is IDLE.
  - mc_stall = (IDLE & mc_start_e & MC_LATENCY>0) | BUSY, gated off by mem_wait.
  - Effect: stall_f/d/e, flush_m.
  - mem_wait freezes the counter. The counter counts only cycles where mem_wait=0.
- Branch: flush_d = flush_e = pc_src_e & ~mem_wait & ~mc_stall. A branch held in E by either stall takes effect in its first unfrozen cycle.
- Priority: mem_wait > mc_stall > branch > load_use.
  - Branch and load_use together: flush_d, flush_e, no stall_f/d. The branch wins and the loaded-after instruction is discarded.
  - mc_stall and load_use together: mc_stall outputs only. Decode is already held by stall_d.
- stall_cycles increments on every edge where stall_f=1. It saturates at all-ones and does not wrap.

## Timing
- Reset (rst=0, asynchronous):
  - FSM to IDLE, MC counter 0, stall_cycles 0, mc_busy 0.
  - flush_d, flush_e, flush_m, flush_w forced 1.
  - All stall_* forced 0. forward_* follow inputs.
- Reset during BUSY aborts the op. After release, the FSM restarts from IDLE on whatever mc_start_e shows.
- Forwarding, load_use, mem_wait and branch outputs have zero latency: same cycle as the inputs.
- mc_stall asserts in the same cycle mc_start_e first rises in IDLE.
  - It stays high for exactly MC_LATENCY consecutive non-mem_wait cycles.
  - It drops one cycle before the FSM returns to IDLE (the DONE cycle).
- mc_busy = state!=IDLE, registered.
- MC_LATENCY=0: the FSM never leaves IDLE and mc_stall is constant 0.

## Test plan
- Forwarding: rd_m=rd_w=rs1_e=5, both reg_write=1 -> forward_a_e=10. Drop reg_write_m -> 01. Set rs1_e=rd_m=rd_w=0 -> 00.
- Load-use: res_src_e=01, reg_write_e=1, rd_e=3, rs2_d=3 -> stall_f=stall_d=flush_e=1 for 1 cycle, stall_cycles +1. Same stimulus with rd_e=0 -> no stall.
- Multi-cycle, MC_LATENCY=4: mc_start_e held high -> stall_f/d/e and flush_m high for exactly 4 cycles, then 1 DONE cycle low, then IDLE. stall_cycles=4.
- Memory wait inside multi-cycle: mem_req_m=1, mem_ready_m=0 for 3 cycles at BUSY count 2 -> stall_f/d/e/m and flush_w high, counter frozen. Total mc stall cycles still 4; 7 cycles of stall_f overall.
- Branch under stall: pc_src_e=1 during mem_wait -> flush_d/e=0. First cycle with mem_ready_m=1 -> flush_d=flush_e=1. Branch with simultaneous load_use -> flushes only, stall_f=0.
- Reset and saturation:
  - rst low mid-BUSY -> mc_busy=0 and all flushes=1 immediately, without waiting for a clock edge.
  - CNT_WIDTH=4 with 20 stall cycles -> stall_cycles=15.
